control_unit: RTL and testbench

Multi-cycle sequencer that drives the 8-bit ALU and register file of the lab processor. Fetches a 32-bit instruction over a valid handshake, decodes it into the ALU SELECT code, operand-mux controls and register addresses, and holds the ALU inputs stable for a programmable number of cycles. It then writes back and updates the PC, taking branches from the ALU's COMP (zero) flag. It sits between instruction memory and the datapath (register file, two's-complement mux, immediate mux, ALU).

---
 rtl/control_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the 8-bit lab processor datapath.
//
// Accepts one 32-bit instruction per FETCH visit over a valid handshake. It
// decodes the instruction into ALU select, operand-mux controls and register
// addresses, then holds them for EXEC_CYCLES cycles. After that it writes back
// and advances the PC, taking beq branches from the ALU zero flag.
//
// Optional build macro: CTRL_ILLEGAL_TRAP_EN -- an undefined opcode parks the
// sequencer in HALT (no fetch, PC frozen) until RESET. Without it an undefined
// opcode behaves as a no-op.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   PC[31:0]              current instruction address
//   FETCH_REQ             high while waiting for an instruction
//   INSTR_VALID           INSTRUCTION valid this cycle (sampled in FETCH only)
//   INSTRUCTION[31:0]     OP[31:24] DEST/OFFSET[23:16] SRC1[15:8] SRC2/IMM[7:0]
//   ALUOP[3:0]            ALU SELECT code
//   IMM_SEL, NEG_SEL      immediate / two's-complement operand-2 mux controls
//   READ_REG1/2, WRITE_REG register-file addresses
//   IMMEDIATE[7:0]        immediate field
//   REG_WRITE             one-cycle register-file write strobe (WB only)
//   COMP                  ALU zero flag, sampled on the last EXEC edge
//   ILLEGAL               sticky undefined-opcode flag
module control_unit #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  output logic        FETCH_REQ,
  input  logic        INSTR_VALID,
  input  logic [31:0] INSTRUCTION,
  output logic [3:0]  ALUOP,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic [2:0]  READ_REG1,
  output logic [2:0]  READ_REG2,
  output logic [2:0]  WRITE_REG,
  output logic [7:0]  IMMEDIATE,
  output logic        REG_WRITE,
  input  logic        COMP,
  output logic        ILLEGAL
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;
`endif

  typedef struct packed {
    logic       legal;
    logic       wr;
    logic       imm;
    logic       neg;
    logic [3:0] alu;
  } dec_t;

  localparam logic [2:0] CNT_INIT = 3'(EXEC_CYCLES - 1);

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d = '{legal: 1'b1, wr: 1'b1, imm: 1'b0, neg: 1'b0, alu: 4'b0000};
    case (op)
      8'h00: d.imm = 1'b1;
      8'h01: ;
      8'h02: d.alu = 4'b0001;
      8'h03: begin d.alu = 4'b0001; d.neg = 1'b1; end
      8'h04: d.alu = 4'b0010;
      8'h05: d.alu = 4'b0011;
      8'h06: d.wr = 1'b0;
      8'h07: begin d.alu = 4'b0001; d.neg = 1'b1; d.wr = 1'b0; end
      8'h08: begin d.alu = 4'b0100; d.imm = 1'b1; end
      8'h09: begin d.alu = 4'b0101; d.imm = 1'b1; end
      8'h0A: begin d.alu = 4'b0110; d.imm = 1'b1; end
      8'h0B: begin d.alu = 4'b0111; d.imm = 1'b1; end
      default: begin d.legal = 1'b0; d.wr = 1'b0; end
    endcase
    return d;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  off_q, off_d;
  logic        wr_en_q, wr_en_d;
  logic        jump_q, jump_d;
  logic        beq_q, beq_d;
  logic        bad_q, bad_d;
  logic        take_q, take_d;
  logic [3:0]  aluop_q, aluop_d;
  logic        imm_sel_q, imm_sel_d;
  logic        neg_sel_q, neg_sel_d;
  logic [2:0]  rd1_q, rd1_d;
  logic [2:0]  rd2_q, rd2_d;
  logic [2:0]  wr_q, wr_d;
  logic [7:0]  imm_q, imm_d;
  logic        illegal_q, illegal_d;
  dec_t        dec;
  logic        unused_src1_hi;

  // SRC1 carries a full byte but the register file has only eight entries.
  assign unused_src1_hi = ^INSTRUCTION[15:11];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    wr_en_d   = wr_en_q;
    jump_d    = jump_q;
    beq_d     = beq_q;
    bad_d     = bad_q;
    take_d    = take_q;
    aluop_d   = aluop_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    wr_d      = wr_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    FETCH_REQ = 1'b0;
    REG_WRITE = 1'b0;
    dec       = decode(INSTRUCTION[31:24]);

    case (state_q)
      S_FETCH: begin
        FETCH_REQ = 1'b1;
        // Decoding on the accept edge puts the controls on the pins for the
        // whole DECODE cycle, so the ALU sees them one cycle earlier.
        if (INSTR_VALID) begin
          aluop_d   = dec.alu;
          imm_sel_d = dec.imm;
          neg_sel_d = dec.neg;
          wr_en_d   = dec.wr;
          bad_d     = ~dec.legal;
          jump_d    = (INSTRUCTION[31:24] == 8'h06);
          beq_d     = (INSTRUCTION[31:24] == 8'h07);
          off_d     = INSTRUCTION[23:16];
          wr_d      = INSTRUCTION[18:16];
          rd1_d     = INSTRUCTION[10:8];
          rd2_d     = INSTRUCTION[2:0];
          imm_d     = INSTRUCTION[7:0];
          if (!dec.legal) illegal_d = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_d   = CNT_INIT;
        take_d  = 1'b0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_q == 3'd0) begin
          // Only the final EXEC edge matters; earlier COMP activity is the
          // ALU still settling.
          take_d  = COMP;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WB: begin
        REG_WRITE = wr_en_q;
        state_d   = S_FETCH;
        if (jump_q || (beq_q && take_q))
          pc_d = pc_q + 32'd4 + {{22{off_q[7]}}, off_q, 2'b00};
        else
          pc_d = pc_q + 32'd4;
`ifdef CTRL_ILLEGAL_TRAP_EN
        // Trap keeps PC at the offending instruction for post-mortem.
        if (bad_q) begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end
`endif
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: ;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      cnt_q     <= '0;
      off_q     <= '0;
      wr_en_q   <= 1'b0;
      jump_q    <= 1'b0;
      beq_q     <= 1'b0;
      bad_q     <= 1'b0;
      take_q    <= 1'b0;
      aluop_q   <= '0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      wr_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      wr_en_q   <= wr_en_d;
      jump_q    <= jump_d;
      beq_q     <= beq_d;
      bad_q     <= bad_d;
      take_q    <= take_d;
      aluop_q   <= aluop_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      wr_q      <= wr_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  assign PC        = pc_q;
  assign ALUOP     = aluop_q;
  assign IMM_SEL   = imm_sel_q;
  assign NEG_SEL   = neg_sel_q;
  assign READ_REG1 = rd1_q;
  assign READ_REG2 = rd2_q;
  assign WRITE_REG = wr_q;
  assign IMMEDIATE = imm_q;
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit (default EXEC_CYCLES). A timeline model tracks how
// many cycles have passed since an instruction was accepted and derives every
// output from the opcode tables; a compare process checks it each falling
// edge. Directed literal checks pin the model at key points.
module tb_control_unit;
  localparam int EXEC = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        INSTR_VALID = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        COMP = 1'b0;
  logic [31:0] PC;
  logic        FETCH_REQ, IMM_SEL, NEG_SEL, REG_WRITE, ILLEGAL;
  logic [3:0]  ALUOP;
  logic [2:0]  READ_REG1, READ_REG2, WRITE_REG;
  logic [7:0]  IMMEDIATE;

  control_unit dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .FETCH_REQ(FETCH_REQ),
    .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION), .ALUOP(ALUOP),
    .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .READ_REG1(READ_REG1),
    .READ_REG2(READ_REG2), .WRITE_REG(WRITE_REG), .IMMEDIATE(IMMEDIATE),
    .REG_WRITE(REG_WRITE), .COMP(COMP), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode tables, indexed by OP for OP 0x00..0x0B.
  logic [3:0] t_alu [12] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
  bit         t_imm [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  bit         t_neg [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
  bit         t_wr  [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};

  // Model state: age 0 = waiting in fetch, 1 = decode, 2..EXEC+1 = exec,
  // EXEC+2 = write-back.
  int          m_age = 0;
  bit          m_halt = 0;
  bit          m_ill = 0;
  bit          m_take = 0;
  logic [31:0] m_pc = '0;
  logic [7:0]  m_op = '0, m_off = '0, m_imm = '0;
  logic [3:0]  m_alu = '0;
  bit          m_imms = 0, m_negs = 0, m_wen = 0;
  logic [2:0]  m_rd1 = '0, m_rd2 = '0, m_wr = '0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_age = 0; m_halt = 0; m_ill = 0; m_take = 0; m_pc = '0;
      m_alu = '0; m_imms = 0; m_negs = 0; m_wen = 0;
      m_rd1 = '0; m_rd2 = '0; m_wr = '0; m_imm = '0; m_op = '0; m_off = '0;
    end else if (m_halt) begin
    end else if (m_age == 0) begin
      if (INSTR_VALID) begin
        m_op  = INSTRUCTION[31:24];
        m_off = INSTRUCTION[23:16];
        m_wr  = INSTRUCTION[18:16];
        m_rd1 = INSTRUCTION[10:8];
        m_rd2 = INSTRUCTION[2:0];
        m_imm = INSTRUCTION[7:0];
        if (m_op < 8'd12) begin
          m_alu = t_alu[int'(m_op)]; m_imms = t_imm[int'(m_op)];
          m_negs = t_neg[int'(m_op)]; m_wen = t_wr[int'(m_op)];
        end else begin
          m_alu = 4'd0; m_imms = 0; m_negs = 0; m_wen = 0; m_ill = 1;
        end
        m_age = 1;
      end
    end else if (m_age == EXEC + 1) begin
      m_take = COMP;
      m_age++;
    end else if (m_age == EXEC + 2) begin
      m_age = 0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (m_op >= 8'd12) m_halt = 1;
      else
`endif
      if (m_op == 8'h06 || (m_op == 8'h07 && m_take))
        m_pc = m_pc + 4 + (32'(signed'(m_off)) * 4);
      else
        m_pc = m_pc + 4;
    end else begin
      m_age++;
    end
  end

  always @(negedge CLK) begin
    chk("pc", PC, m_pc);
    chk("fetch_req", FETCH_REQ, (m_age == 0 && !m_halt));
    chk("reg_write", REG_WRITE, (m_age == EXEC + 2 && m_wen));
    chk("aluop", ALUOP, m_alu);
    chk("imm_sel", IMM_SEL, m_imms);
    chk("neg_sel", NEG_SEL, m_negs);
    chk("read_reg1", READ_REG1, m_rd1);
    chk("read_reg2", READ_REG2, m_rd2);
    chk("write_reg", WRITE_REG, m_wr);
    chk("immediate", IMMEDIATE, m_imm);
    chk("illegal", ILLEGAL, m_ill);
  end

  // Waits for FETCH_REQ, optionally delays, presents ins; returns at the
  // DECODE falling edge + 1. fr = cycles FETCH_REQ was seen high.
  task automatic issue(input logic [31:0] ins, input int delay, input bit hold, output int fr);
    int waited = 0;
    fr = 0;
    while (FETCH_REQ !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (FETCH_REQ !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_wait: FETCH_REQ=%b after %0d cycles, required 1", FETCH_REQ, waited);
      return;
    end
    fr = 1;
    repeat (delay) begin
      @(negedge CLK);
      if (FETCH_REQ === 1'b1) fr++;
    end
    #1;
    INSTR_VALID = 1'b1;
    INSTRUCTION = ins;
    @(negedge CLK);
    #1;
    if (!hold) INSTR_VALID = 1'b0;
    else INSTRUCTION = 32'hFF00_0000;
  endtask

  // mode 0: COMP low; 1: COMP high throughout; 2: pulse in first EXEC cycle.
  // Returns at the WB falling edge + 1.
  task automatic finish(input int mode, input bit hold);
    for (int k = 1; k <= EXEC + 1; k++) begin
      if (k > 1) begin @(negedge CLK); #1; end
      COMP = (mode == 1) || (mode == 2 && k == 2);
    end
    @(negedge CLK);
    #1;
    COMP = 1'b0;
    if (!hold) INSTR_VALID = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins, input int mode, input bit hold);
    int fr;
    issue(ins, 0, hold, fr);
    finish(mode, hold);
  endtask

  initial begin
    int fr;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_pc", PC, 32'h0);
    chk("rst_fetch_req", FETCH_REQ, 1);
    chk("rst_aluop", ALUOP, 0);
    chk("rst_illegal", ILLEGAL, 0);
    #1 RESET = 1'b0;

    // loadi r3, 0x2A
    issue(32'h0003_002A, 0, 0, fr);
    chk("loadi_aluop", ALUOP, 4'b0000);
    chk("loadi_imm_sel", IMM_SEL, 1);
    chk("loadi_immediate", IMMEDIATE, 8'h2A);
    finish(0, 0);
    chk("loadi_reg_write", REG_WRITE, 1);
    chk("loadi_write_reg", WRITE_REG, 3'd3);
    @(negedge CLK);
    chk("loadi_pc", PC, 32'h4);

    // sub r1, r2, r3
    issue(32'h0301_0203, 0, 0, fr);
    chk("sub_aluop", ALUOP, 4'b0001);
    chk("sub_neg_sel", NEG_SEL, 1);
    chk("sub_rd1", READ_REG1, 3'd2);
    chk("sub_rd2", READ_REG2, 3'd3);
    finish(0, 0);

    run(32'h0402_0105, 0, 1);   // and, INSTR_VALID left high
    run(32'h0504_0302, 0, 0);   // or at 0x0C
    run(32'h07FE_0102, 1, 0);   // beq taken at 0x10
    @(negedge CLK);
    chk("beq_taken_pc", PC, 32'h0C);
    run(32'h0101_0200, 0, 0);   // mov at 0x0C
    run(32'h07FE_0102, 0, 0);   // beq not taken at 0x10
    @(negedge CLK);
    chk("beq_not_taken_pc", PC, 32'h14);
    run(32'h06FE_0000, 0, 0);   // j back to 0x10
    @(negedge CLK);
    chk("j_pc", PC, 32'h10);
    run(32'h07FE_0102, 2, 0);   // beq with early COMP glitch
    @(negedge CLK);
    chk("beq_glitch_pc", PC, 32'h14);

    // late INSTR_VALID
    issue(32'h0802_0103, 3, 0, fr);
    chk("late_fetch_cycles", 32'(fr), 32'd4);
    chk("sll_aluop", ALUOP, 4'b0100);
    finish(0, 0);

    // reset in the middle of EXEC of add
    issue(32'h0205_0102, 0, 0, fr);
    @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_aluop", ALUOP, 0);
    chk("midrst_fetch_req", FETCH_REQ, 1);
    chk("midrst_reg_write", REG_WRITE, 0);
    chk("midrst_write_reg", WRITE_REG, 0);
    @(negedge CLK);
    #1 RESET = 1'b0;

    // j with negative offset from PC 0 wraps
    run(32'h06FD_0000, 0, 0);
    @(negedge CLK);
    chk("wrap_pc", PC, 32'hFFFF_FFF8);

    // undefined opcode
    issue(32'hFF01_0203, 0, 0, fr);
    chk("ill_flag", ILLEGAL, 1);
    finish(0, 0);
    chk("ill_reg_write", REG_WRITE, 0);
    @(negedge CLK);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("trap_fetch_req", FETCH_REQ, 0);
    chk("trap_pc", PC, 32'hFFFF_FFF8);
    repeat (3) @(negedge CLK);
    chk("trap_pc_frozen", PC, 32'hFFFF_FFF8);
`else
    chk("nop_pc", PC, 32'hFFFF_FFFC);
    chk("nop_fetch_req", FETCH_REQ, 1);
    run(32'h0001_0007, 0, 0);
    @(negedge CLK);
    chk("after_ill_pc", PC, 32'h0);
    chk("ill_sticky", ILLEGAL, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
